// File: rtl/web_fire_sequencer.sv
// web_fire_sequencer: accepts web-shooter fire requests, checks fluid/energy/
// tracer resources, emits single shots or paced rapid-fire bursts, runs
// fluid-cartridge reloads and recharges energy on a free-running divider.
module web_fire_sequencer #(
  parameter int unsigned FLUID_MAX     = 15,
  parameter int unsigned ENERGY_INIT   = 64,
  parameter int unsigned TRACER_INIT   = 8,
  parameter int unsigned RECHARGE_DIV  = 16,
  parameter int unsigned COOLDOWN      = 3,
  parameter int unsigned BURST         = 4,
  parameter int unsigned SHOT_GAP      = 2,
  parameter int unsigned RELOAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       req,
  input  logic [2:0] select,
  output logic       ack,
  output logic       fire,
  output logic [7:0] web,
  output logic       deny,
  output logic       busy,
  output logic [3:0] fluid,
  output logic [7:0] energy,
  output logic [5:0] tracers,
  output logic       fluid_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_CHECK,
    S_FIRE,
    S_GAP,
    S_COOL,
    S_DENY,
    S_RELOAD
  } state_t;

  localparam logic [2:0] C_RAPID  = 3'd5;
  localparam logic [2:0] C_RELOAD = 3'd7;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_choice;
  logic [7:0]  r_shots;
  logic [7:0]  r_cnt;
  logic [15:0] r_div;
  logic [3:0]  r_fluid;
  logic [7:0]  r_energy;
  logic [5:0]  r_tracers;

  logic [3:0]  w_cost_fluid;
  logic [7:0]  w_cost_energy;
  logic [5:0]  w_cost_tracer;
  logic        w_ok;
  logic        w_debit;
  logic        w_recharge;
  logic [3:0]  w_fluid_after;
  logic [8:0]  w_energy_sum;

  // Per-choice resource cost table
  always_comb begin
    w_cost_fluid  = '0;
    w_cost_energy = '0;
    w_cost_tracer = '0;
    case (r_choice)
      3'd0, 3'd1, 3'd5: w_cost_fluid = 4'd1;
      3'd2:             w_cost_fluid = 4'd2;
      3'd3:             w_cost_fluid = 4'd4;
      3'd4: begin
        w_cost_fluid  = 4'd1;
        w_cost_energy = 8'd16;
      end
      3'd6: begin
        w_cost_energy = 8'd2;
        w_cost_tracer = 6'd1;
      end
      default: ;
    endcase
  end

  assign w_ok          = (r_fluid >= w_cost_fluid) && (r_energy >= w_cost_energy) &&
                         (r_tracers >= w_cost_tracer);
  assign w_debit       = (r_state == S_FIRE);
  assign w_recharge    = (r_div == 16'(RECHARGE_DIV - 1));
  assign w_fluid_after = r_fluid - w_cost_fluid;

  // Energy after this edge: debit and recharge may coincide, saturate at 255
  always_comb begin
    w_energy_sum = {1'b0, r_energy};
    if (w_debit) begin
      w_energy_sum = w_energy_sum - {1'b0, w_cost_energy};
    end
    if (w_recharge) begin
      w_energy_sum = w_energy_sum + 9'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; dropping enable aborts everything except a reload
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && req) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        w_next = enable ? S_CHECK : S_IDLE;
      end
      S_CHECK: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (r_choice == C_RELOAD) begin
          w_next = S_RELOAD;
        end else if (w_ok) begin
          w_next = S_FIRE;
        end else begin
          w_next = S_DENY;
        end
      end
      S_FIRE: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if ((r_choice == C_RAPID) && (r_shots > 8'd1) && (w_fluid_after >= 4'd1)) begin
          w_next = S_GAP;
        end else begin
          w_next = S_COOL;
        end
      end
      S_GAP: begin
        if (!enable) begin
          w_next = S_IDLE;
        end else if (r_cnt == 8'(SHOT_GAP - 1)) begin
          w_next = S_FIRE;
        end
      end
      S_COOL: begin
        if (!enable || (r_cnt == 8'(COOLDOWN - 1))) begin
          w_next = S_IDLE;
        end
      end
      S_DENY: begin
        w_next = S_IDLE;
      end
      S_RELOAD: begin
        if (r_cnt == 8'(RELOAD_CYCLES - 1)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state dwell counter, cleared on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Latch the decoded choice on acceptance; track remaining burst shots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_choice <= '0;
      r_shots  <= '0;
    end else begin
      if (r_state == S_IDLE && enable && req) begin
        r_choice <= {select[0], select[1], select[2]};
      end
      if (r_state == S_CHECK) begin
        r_shots <= 8'(BURST);
      end else if (r_state == S_FIRE) begin
        r_shots <= r_shots - 8'd1;
      end
    end
  end

  // Free-running energy recharge divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_recharge) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // Resource bookkeeping: debit on the FIRE edge, refill at reload completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fluid   <= 4'(FLUID_MAX);
      r_energy  <= 8'(ENERGY_INIT);
      r_tracers <= 6'(TRACER_INIT);
    end else begin
      if (r_state == S_RELOAD && w_next == S_IDLE) begin
        r_fluid <= 4'(FLUID_MAX);
      end else if (w_debit) begin
        r_fluid <= w_fluid_after;
      end
      if (w_debit) begin
        r_tracers <= r_tracers - w_cost_tracer;
      end
      r_energy <= w_energy_sum[8] ? 8'hFF : w_energy_sum[7:0];
    end
  end

  assign ack         = (r_state == S_ACK);
  assign fire        = (r_state == S_FIRE);
  assign deny        = (r_state == S_DENY);
  assign busy        = (r_state != S_IDLE);
  assign web         = fire ? (8'h80 >> r_choice) : '0;
  assign fluid       = r_fluid;
  assign energy      = r_energy;
  assign tracers     = r_tracers;
  assign fluid_empty = (r_fluid == 4'd0);

endmodule

// File: tb/tb_web_fire_sequencer.sv
// Bench for web_fire_sequencer: a per-cycle schedule model predicts every
// output, plus directed scenarios with hand-computed latencies and levels.
module tb_web_fire_sequencer;

  localparam int FLUID_MAX     = 15;
  localparam int ENERGY_INIT   = 64;
  localparam int TRACER_INIT   = 8;
  localparam int RECHARGE_DIV  = 16;
  localparam int COOLDOWN      = 3;
  localparam int BURST         = 4;
  localparam int SHOT_GAP      = 2;
  localparam int RELOAD_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       req = 1'b0;
  logic [2:0] select = 3'd0;
  logic       ack, fire, deny, busy, fluid_empty;
  logic [7:0] web, energy;
  logic [3:0] fluid;
  logic [5:0] tracers;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  web_fire_sequencer #(
    .FLUID_MAX    (FLUID_MAX),
    .ENERGY_INIT  (ENERGY_INIT),
    .TRACER_INIT  (TRACER_INIT),
    .RECHARGE_DIV (RECHARGE_DIV),
    .COOLDOWN     (COOLDOWN),
    .BURST        (BURST),
    .SHOT_GAP     (SHOT_GAP),
    .RELOAD_CYCLES(RELOAD_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .enable     (enable),
    .req        (req),
    .select     (select),
    .ack        (ack),
    .fire       (fire),
    .web        (web),
    .deny       (deny),
    .busy       (busy),
    .fluid      (fluid),
    .energy     (energy),
    .tracers    (tracers),
    .fluid_empty(fluid_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- schedule model ----------------
  // Each accepted request expands into a list of expected busy cycles.
  typedef struct {
    bit ack;
    bit fire;
    bit deny;
    bit chk;
    bit rel;
    bit full;
    int ch;
    int df;
    int de;
    int dt;
  } rec_t;

  rec_t mq[$];
  int m_fluid, m_energy, m_tr, m_edges;

  function automatic rec_t mk(input bit a, input bit fi, input bit d, input bit c, input bit rl,
                              input bit fu, input int ch, input int df, input int de, input int dt);
    rec_t r;
    r.ack = a; r.fire = fi; r.deny = d; r.chk = c; r.rel = rl; r.full = fu;
    r.ch = ch; r.df = df; r.de = de; r.dt = dt;
    return r;
  endfunction

  function automatic void cost_of(input int ch, output int f, output int e, output int t);
    f = 0; e = 0; t = 0;
    case (ch)
      0, 1, 5: f = 1;
      2: f = 2;
      3: f = 4;
      4: begin f = 1; e = 16; end
      6: begin e = 2; t = 1; end
      default: ;
    endcase
  endfunction

  always begin : model
    rec_t r;
    bit   was_idle;
    int   f, e, t, shots, ch;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_fluid  = FLUID_MAX;
      m_energy = ENERGY_INIT;
      m_tr     = TRACER_INIT;
      m_edges  = 0;
      mq.delete();
    end else begin
      was_idle = (mq.size() == 0);
      m_edges++;
      if (!was_idle) begin
        r = mq.pop_front();
        if (r.chk) begin
          if (r.ch == 7) begin
            for (int i = 0; i < RELOAD_CYCLES; i++)
              mq.push_back(mk(0, 0, 0, 0, 1, (i == RELOAD_CYCLES - 1), 7, 0, 0, 0));
          end else begin
            cost_of(r.ch, f, e, t);
            if (m_fluid >= f && m_energy >= e && m_tr >= t) begin
              shots = (r.ch == 5) ? ((m_fluid < BURST) ? m_fluid : BURST) : 1;
              for (int s = 0; s < shots; s++) begin
                mq.push_back(mk(0, 1, 0, 0, 0, 0, r.ch, f, e, t));
                if (s < shots - 1)
                  for (int g = 0; g < SHOT_GAP; g++) mq.push_back(mk(0, 0, 0, 0, 0, 0, r.ch, 0, 0, 0));
              end
              for (int c = 0; c < COOLDOWN; c++) mq.push_back(mk(0, 0, 0, 0, 0, 0, r.ch, 0, 0, 0));
            end else begin
              mq.push_back(mk(0, 0, 1, 0, 0, 0, r.ch, 0, 0, 0));
            end
          end
        end
        m_fluid  -= r.df;
        m_energy -= r.de;
        m_tr     -= r.dt;
        if (r.full) m_fluid = FLUID_MAX;
        if (!enable && !r.rel) mq.delete();
      end
      if ((m_edges % RECHARGE_DIV) == 0 && m_energy < 255) m_energy++;
      if (was_idle && enable && req) begin
        ch = {29'd0, select[0], select[1], select[2]};
        mq.push_back(mk(1, 0, 0, 0, 0, 0, ch, 0, 0, 0));
        mq.push_back(mk(0, 0, 0, 1, 0, 0, ch, 0, 0, 0));
      end
    end
  end

  // Compare every cycle, 1 time unit after the rising edge
  always begin : compare
    int ea, ef, ed, eb, ew;
    @(posedge clk);
    #1;
    if (!rst) begin
      ea = 0; ef = 0; ed = 0; eb = 0; ew = 0;
      if (mq.size() > 0) begin
        ea = mq[0].ack;
        ef = mq[0].fire;
        ed = mq[0].deny;
        eb = 1;
        ew = mq[0].fire ? (1 << (7 - mq[0].ch)) : 0;
      end
      chk("ack", ack, ea);
      chk("fire", fire, ef);
      chk("deny", deny, ed);
      chk("busy", busy, eb);
      chk("web", web, ew);
      chk("fluid", fluid, m_fluid);
      chk("energy", energy, m_energy);
      chk("tracers", tracers, m_tr);
      chk("fluid_empty", fluid_empty, (m_fluid == 0) ? 1 : 0);
    end
  end

  // ---------------- event monitor ----------------
  int ack_cnt, fire_cnt, deny_cnt, ack_lbl, deny_lbl;
  int fire_lbl[16];

  always begin : monitor
    @(negedge clk);
    if (!rst) begin
      if (ack) begin ack_cnt++; ack_lbl = cyc + 1; end
      if (fire) begin
        if (fire_cnt < 16) fire_lbl[fire_cnt] = cyc + 1;
        fire_cnt++;
      end
      if (deny) begin deny_cnt++; deny_lbl = cyc + 1; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_fire"}, fire, 0);
    chk({tag, "_deny"}, deny, 0);
    chk({tag, "_web"}, web, 0);
    chk({tag, "_fluid"}, fluid, 15);
    chk({tag, "_energy"}, energy, 64);
    chk({tag, "_tracers"}, tracers, 8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  // Returns the label of the sampling edge; label of cycle after edge k is k+1
  task automatic request(input logic [2:0] sel, output int edge_n);
    int n;
    @(negedge clk);
    ack_cnt = 0; fire_cnt = 0; deny_cnt = 0;
    select = sel;
    req = 1'b1;
    edge_n = cyc + 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    if (!ack) chk("ack_timeout", 0, 1);
    req = 1'b0;
  endtask

  task automatic wait_idle(output int lbl);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (busy) chk("idle_timeout", 0, 1);
    lbl = cyc + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, il, tot_fire, tot_deny, n;

    // A: single swing shot
    do_reset();
    enable = 1'b1;
    request(3'b000, e);
    wait_idle(il);
    chk("A_ack_latency", ack_lbl - e, 1);
    chk("A_fire_latency", fire_lbl[0] - e, 3);
    chk("A_fire_count", fire_cnt, 1);
    chk("A_idle_latency", il - e, 7);
    chk("A_fluid", fluid, 14);

    // Requests ignored while disarmed
    enable = 1'b0;
    @(negedge clk);
    ack_cnt = 0;
    req = 1'b1;
    repeat (6) @(negedge clk);
    chk("noen_ack_count", ack_cnt, 0);
    chk("noen_busy", busy, 0);
    req = 1'b0;
    enable = 1'b1;

    // B: full rapid-fire burst from full fluid
    do_reset();
    request(3'b101, e);
    wait_idle(il);
    chk("B_fire_count", fire_cnt, 4);
    chk("B_shot0", fire_lbl[0] - e, 3);
    chk("B_shot1", fire_lbl[1] - e, 6);
    chk("B_shot2", fire_lbl[2] - e, 9);
    chk("B_shot3", fire_lbl[3] - e, 12);
    chk("B_idle_latency", il - e, 16);
    chk("B_fluid", fluid, 11);

    // C: drain to 2, then grenade is denied
    request(3'b110, e); wait_idle(il);
    chk("C_fluid_7", fluid, 7);
    request(3'b110, e); wait_idle(il);
    chk("C_fluid_3", fluid, 3);
    request(3'b000, e); wait_idle(il);
    chk("C_fluid_2", fluid, 2);
    request(3'b110, e); wait_idle(il);
    chk("C_deny_count", deny_cnt, 1);
    chk("C_deny_latency", deny_lbl - e, 3);
    chk("C_deny_nofire", fire_cnt, 0);
    chk("C_deny_fluid", fluid, 2);

    // D: truncated burst, then reload
    request(3'b101, e); wait_idle(il);
    chk("D_fire_count", fire_cnt, 2);
    chk("D_deny_count", deny_cnt, 0);
    chk("D_fluid", fluid, 0);
    chk("D_empty", fluid_empty, 1);
    request(3'b111, e); wait_idle(il);
    chk("D_reload_latency", il - e, 11);
    chk("D_reload_fluid", fluid, 15);
    chk("D_reload_nofire", fire_cnt, 0);

    // E: tracers until exhausted
    do_reset();
    tot_fire = 0; tot_deny = 0;
    for (int i = 0; i < 9; i++) begin
      request(3'b011, e);
      wait_idle(il);
      tot_fire += fire_cnt;
      tot_deny += deny_cnt;
    end
    chk("E_fire_total", tot_fire, 8);
    chk("E_deny_total", tot_deny, 1);
    chk("E_tracers", tracers, 0);

    // F: drop enable in the gap after the first rapid shot
    do_reset();
    request(3'b101, e);
    n = 0;
    while (!fire && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!fire) chk("F_fire_timeout", 0, 1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("F_idle_next", busy, 0);
    repeat (5) @(negedge clk);
    chk("F_fire_count", fire_cnt, 1);
    chk("F_fluid", fluid, 14);
    enable = 1'b1;

    // Reset in the middle of a reload
    request(3'b111, e);
    repeat (3) @(negedge clk);
    chk("F_reload_busy", busy, 1);
    chk("F_reload_fluid", fluid, 14);
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    request(3'b000, e);
    wait_idle(il);
    chk("F_after_reset_fluid", fluid, 14);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
